demux_scheduler: RTL and testbench
==================================

# demux_scheduler

Sequencing controller for the 1-to-4 nibble demultiplexer. It accepts a stream of words through a valid/ready handshake and buffers one word at a time. Each word goes to the next enabled destination in round-robin order. The block drives the demultiplexer's `Select`, `Enable` and `MUX` inputs and waits for the chosen destination's ready. It drops a word when no destination is enabled, or when the chosen destination stalls too long.

## Interface
- `WIDTH`, 4: data word width; matches the demultiplexer data input.
- `STALL_LIMIT`, 8: maximum cycles a word is offered to one destination before it is dropped; legal range 2..255.
- `clk`  input  1  sole clock, rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `InValid`  input  1  upstream word valid.
- `InData`  input  WIDTH  upstream word.
- `InReady`  output  1  block can accept a word this cycle.
- `DestMask`  input  4  bit i = 1 enables destination i (0=A, 1=B, 2=C, 3=D).
- `DestReady`  input  4  bit i = 1 means destination i consumes the offered word this cycle.
- `Select`  output  2  demultiplexer select, registered.
- `Enable`  output  1  demultiplexer enable, registered.
- `MUX`  output  WIDTH  buffered word driven to the demultiplexer, registered.
- `DropCount`  output  8  dropped-word counter; saturates at 255.
- `Busy`  output  1  high while a word is held (state SEND).

## Operation
- Two states, IDLE and SEND, plus a 2-bit round-robin pointer `ptr`, a 2-bit target register and a stall counter.
- IDLE:
  - `InReady` = 1 and `Enable` = 0.
  - On `InValid & InReady` with `DestMask != 0`: `MUX <= InData`; target = first i with `DestMask[i]=1`, searching from `ptr` upward and wrapping 3→0; `Select <= target`; stall counter <= 0; go to SEND.
  - On `InValid & InReady` with `DestMask == 0`: the word is accepted and discarded; `DropCount` += 1 (saturating); stay in IDLE.
- SEND:
  - `InReady` = 0, `Enable` = 1, `Busy` = 1; `Select` and `MUX` are held stable.
  - If `DestReady[target]` = 1: transfer completes at this edge; `ptr <= target+1` (mod 4); go to IDLE.
  - Else, if stall counter = `STALL_LIMIT-1`: drop the word; `DropCount` += 1; `ptr <= target+1`; go to IDLE.
  - Else: stall counter += 1.
- `DestMask` is sampled only at capture. Mask changes during SEND do not retarget the held word.
- `DestReady` bits other than the target bit are ignored.
- `DropCount` holds at 255 and does not wrap.
- `MUX` retains the last word after a transfer; only `Enable` qualifies it.

## Timing
- Reset values: state IDLE, `ptr` 0, `Select` 0, `Enable` 0, `MUX` 0, `DropCount` 0, `Busy` 0.
- `InReady` is 0 while `reset` is high and equals (state == IDLE) otherwise.
- Capture at edge N → `Enable`/`Select`/`MUX` valid from edge N through at least edge N+1.
- With `DestReady[target]` high in the first SEND cycle, the transfer occurs at edge N+1. `Enable` falls and `InReady` rises after N+1.
- Peak throughput is one word per 2 cycles.
- Stall: `Enable` stays high for exactly `STALL_LIMIT` cycles when the target is never ready. The drop occurs at the edge ending the `STALL_LIMIT`-th SEND cycle.
- Ready arriving in the last stall cycle wins: the transfer completes and there is no drop.
- Reset asserted mid-SEND clears `Enable` immediately (asynchronously). The held word is lost and not counted.

## Test plan
- Reset → all outputs at reset values. After release with `InValid`=0, `InReady`=1 and `Enable`=0 indefinitely.
- `DestMask`=1111, all `DestReady`=1, words 0xA,0xB,0xC,0xD,0xE back-to-back → `Select` 0,1,2,3,0 with `MUX` 0xA..0xE. Each `Enable` pulse lasts 1 cycle. `InReady` alternates 1/0. `DropCount`=0.
- `DestMask`=1010, all ready, words 0x1,0x2,0x3 → `Select` 1,3,1; `MUX` 0x1,0x2,0x3.
- `DestMask`=1111, `DestReady[0]`=0 for 3 SEND cycles then 1, word 0x5 → `Enable` high 4 cycles, `MUX`=0x5 stable, `DropCount` unchanged. The next word goes to `Select`=1.
- `STALL_LIMIT`=8, `DestMask`=1111, `ptr` at 2, `DestReady[2]` stuck 0, words 0x6 then 0x7 → `Enable` high exactly 8 cycles and `DropCount`=1. 0x7 then goes to `Select`=3.
- Stall-limit boundary: `STALL_LIMIT`=8, `DestReady[target]` rises only in the 8th SEND cycle → transfer completes and `DropCount` unchanged.
- `DestMask`=0000, 300 words → `Enable` never asserted and `DropCount`=255 (saturated).
- Reset pulsed during SEND → `Enable`=0 before the next clock edge and `DropCount` cleared to 0.

Source files
------------

// File: rtl/demux_scheduler.sv
// Sequencing controller for the 1-to-4 nibble demultiplexer: buffers one word,
// steers it round-robin to an enabled destination, and drops on no-target or stall.
module demux_scheduler #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned STALL_LIMIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InValid,
    input  logic [WIDTH-1:0] InData,
    output logic             InReady,
    input  logic [3:0]       DestMask,
    input  logic [3:0]       DestReady,
    output logic [1:0]       Select,
    output logic             Enable,
    output logic [WIDTH-1:0] MUX,
    output logic [7:0]       DropCount,
    output logic             Busy
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_LIMIT - 1);
    localparam logic [7:0]       DROP_MAX   = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e           state_q;
    logic [1:0]       ptr_q;
    logic [1:0]       select_q;
    logic             enable_q;
    logic             busy_q;
    logic [WIDTH-1:0] mux_q;
    logic [7:0]       drop_q;
    logic [CNT_W-1:0] stall_q;
    logic [1:0]       target_c;

    // First enabled destination at or after ptr; descending loop lets the nearest win.
    always_comb begin
        logic [1:0] idx;
        target_c = ptr_q;
        idx      = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (DestMask[idx]) begin
                target_c = idx;
            end
        end
    end

    assign InReady   = ~reset & (state_q == IDLE);
    assign Select    = select_q;
    assign Enable    = enable_q;
    assign MUX       = mux_q;
    assign DropCount = drop_q;
    assign Busy      = busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd0;
            select_q <= 2'd0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            mux_q    <= '0;
            drop_q   <= 8'd0;
            stall_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (InValid) begin
                        if (DestMask != 4'd0) begin
                            mux_q    <= InData;
                            select_q <= target_c;
                            stall_q  <= '0;
                            enable_q <= 1'b1;
                            busy_q   <= 1'b1;
                            state_q  <= SEND;
                        end else if (drop_q != DROP_MAX) begin
                            drop_q <= drop_q + 8'd1;
                        end
                    end
                end
                SEND: begin
                    if (DestReady[select_q]) begin
                        ptr_q    <= select_q + 2'd1;
                        enable_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else if (stall_q == STALL_LAST) begin
                        if (drop_q != DROP_MAX) begin
                            drop_q <= drop_q + 8'd1;
                        end
                        ptr_q    <= select_q + 2'd1;
                        enable_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        stall_q <= stall_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    enable_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_scheduler.sv
// Directed bench for demux_scheduler: round-robin steering, stalls, drops, saturation, reset.
module tb_demux_scheduler;

    logic       clk;
    logic       reset;
    logic       InValid;
    logic [3:0] InData;
    logic       InReady;
    logic [3:0] DestMask;
    logic [3:0] DestReady;
    logic [1:0] Select;
    logic       Enable;
    logic [3:0] MUX;
    logic [7:0] DropCount;
    logic       Busy;

    int checks;
    int failures;

    demux_scheduler #(.WIDTH(4), .STALL_LIMIT(8)) dut (
        .clk(clk), .reset(reset), .InValid(InValid), .InData(InData),
        .InReady(InReady), .DestMask(DestMask), .DestReady(DestReady),
        .Select(Select), .Enable(Enable), .MUX(MUX),
        .DropCount(DropCount), .Busy(Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        checks++;
        if ({Select, Enable, MUX, DropCount, Busy, InReady} !== 17'd0) begin
            failures++;
            $display("FAIL reset_values got sel=%0d en=%0b mux=%0h drop=%0d busy=%0b rdy=%0b exp all 0",
                     Select, Enable, MUX, DropCount, Busy, InReady);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (InReady !== 1'b1 || Enable !== 1'b0) begin
                failures++;
                $display("FAIL idle_after_reset cyc=%0d got rdy=%0b en=%0b exp rdy=1 en=0", i, InReady, Enable);
            end
        end
    endtask

    task automatic send_words(input logic [3:0] mask, input logic [3:0] w [3:0],
                              input logic [1:0] exp_sel [3:0], input int n, input string name);
        DestMask  = mask;
        DestReady = 4'b1111;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (InReady !== 1'b1 || Enable !== 1'b0) begin
                failures++;
                $display("FAIL %s_idle w=%0d got rdy=%0b en=%0b exp rdy=1 en=0", name, i, InReady, Enable);
            end
            InValid = 1'b1;
            InData  = w[i];
            @(negedge clk);
            checks++;
            if (Enable !== 1'b1 || Select !== exp_sel[i] || MUX !== w[i] || InReady !== 1'b0 || Busy !== 1'b1) begin
                failures++;
                $display("FAIL %s_send w=%0d got en=%0b sel=%0d mux=%0h rdy=%0b busy=%0b exp en=1 sel=%0d mux=%0h rdy=0 busy=1",
                         name, i, Enable, Select, MUX, InReady, Busy, exp_sel[i], w[i]);
            end
            if (i == n - 1) InValid = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (Enable !== 1'b0 || InReady !== 1'b1) begin
            failures++;
            $display("FAIL %s_end got en=%0b rdy=%0b exp en=0 rdy=1", name, Enable, InReady);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] w [3:0];
        logic [1:0] s [3:0];
        w = '{4'hD, 4'hC, 4'hB, 4'hA};
        s = '{2'd3, 2'd2, 2'd1, 2'd0};
        send_words(4'b1111, w, s, 4, "rr_all");
        w = '{4'h0, 4'h0, 4'h0, 4'hE};
        s = '{2'd0, 2'd0, 2'd0, 2'd0};
        send_words(4'b1111, w, s, 1, "rr_wrap");
        checks++;
        if (DropCount !== 8'd0) begin
            failures++;
            $display("FAIL rr_dropcount got %0d exp 0", DropCount);
        end
    endtask

    task automatic test_sparse_mask();
        logic [3:0] w [3:0];
        logic [1:0] s [3:0];
        w = '{4'h0, 4'h3, 4'h2, 4'h1};
        s = '{2'd0, 2'd1, 2'd3, 2'd1};
        send_words(4'b1010, w, s, 3, "mask1010");
    endtask

    // ptr is 2 here; target 2 never ready -> dropped, then 0x7 goes to D.
    task automatic test_stall_drop();
        int n;
        DestMask  = 4'b1111;
        DestReady = 4'b1011;
        InValid   = 1'b1;
        InData    = 4'h6;
        n = 0;
        @(negedge clk);
        while (Enable === 1'b1 && n < 20) begin
            n++;
            checks++;
            if (Select !== 2'd2 || MUX !== 4'h6 || DropCount !== 8'd0) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got sel=%0d mux=%0h drop=%0d exp sel=2 mux=6 drop=0",
                         n, Select, MUX, DropCount);
            end
            InData = 4'h7;
            @(negedge clk);
        end
        checks++;
        if (n !== 8) begin
            failures++;
            $display("FAIL stall_enable_len got %0d exp 8", n);
        end
        checks++;
        if (DropCount !== 8'd1 || InReady !== 1'b1) begin
            failures++;
            $display("FAIL stall_drop got drop=%0d rdy=%0b exp drop=1 rdy=1", DropCount, InReady);
        end
        @(negedge clk);
        InValid = 1'b0;
        checks++;
        if (Enable !== 1'b1 || Select !== 2'd3 || MUX !== 4'h7) begin
            failures++;
            $display("FAIL after_drop got en=%0b sel=%0d mux=%0h exp en=1 sel=3 mux=7", Enable, Select, MUX);
        end
        @(negedge clk);
        checks++;
        if (Enable !== 1'b0) begin
            failures++;
            $display("FAIL after_drop_done got en=%0b exp 0", Enable);
        end
    endtask

    // Target 0 (ptr 0) not ready for 3 cycles, ready in the 4th.
    task automatic test_stall_recover();
        int n;
        logic [3:0] w [3:0];
        logic [1:0] s [3:0];
        DestMask  = 4'b1111;
        DestReady = 4'b1110;
        InValid   = 1'b1;
        InData    = 4'h5;
        n = 0;
        @(negedge clk);
        InValid = 1'b0;
        while (Enable === 1'b1 && n < 20) begin
            n++;
            checks++;
            if (Select !== 2'd0 || MUX !== 4'h5) begin
                failures++;
                $display("FAIL recover_hold cyc=%0d got sel=%0d mux=%0h exp sel=0 mux=5", n, Select, MUX);
            end
            if (n == 4) DestReady = 4'b1111;
            @(negedge clk);
        end
        checks++;
        if (n !== 4 || DropCount !== 8'd1) begin
            failures++;
            $display("FAIL recover_len got len=%0d drop=%0d exp len=4 drop=1", n, DropCount);
        end
        w = '{4'h0, 4'h0, 4'h0, 4'h8};
        s = '{2'd0, 2'd0, 2'd0, 2'd1};
        send_words(4'b1111, w, s, 1, "recover_next");
    endtask

    // Ready arrives in the 8th (last) SEND cycle: transfer, no drop.
    task automatic test_stall_boundary();
        int n;
        DestMask  = 4'b1111;
        DestReady = 4'b1011;
        InValid   = 1'b1;
        InData    = 4'h9;
        n = 0;
        @(negedge clk);
        InValid = 1'b0;
        while (Enable === 1'b1 && n < 20) begin
            n++;
            if (n == 8) DestReady = 4'b1111;
            @(negedge clk);
        end
        checks++;
        if (n !== 8 || DropCount !== 8'd1) begin
            failures++;
            $display("FAIL boundary got len=%0d drop=%0d exp len=8 drop=1", n, DropCount);
        end
    endtask

    task automatic test_saturate();
        int en_seen;
        en_seen   = 0;
        DestMask  = 4'b0000;
        DestReady = 4'b1111;
        InValid   = 1'b1;
        for (int i = 0; i < 300; i++) begin
            InData = 4'(i);
            @(negedge clk);
            if (Enable !== 1'b0) en_seen++;
        end
        InValid = 1'b0;
        checks++;
        if (en_seen !== 0) begin
            failures++;
            $display("FAIL sat_enable got %0d enable cycles exp 0", en_seen);
        end
        checks++;
        if (DropCount !== 8'd255 || InReady !== 1'b1) begin
            failures++;
            $display("FAIL sat_count got drop=%0d rdy=%0b exp drop=255 rdy=1", DropCount, InReady);
        end
    endtask

    task automatic test_reset_mid_send();
        DestMask  = 4'b1111;
        DestReady = 4'b0000;
        InValid   = 1'b1;
        InData    = 4'hF;
        @(negedge clk);
        InValid = 1'b0;
        checks++;
        if (Enable !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre got en=%0b exp 1", Enable);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (Enable !== 1'b0 || DropCount !== 8'd0 || InReady !== 1'b0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid got en=%0b drop=%0d rdy=%0b busy=%0b exp en=0 drop=0 rdy=0 busy=0",
                     Enable, DropCount, InReady, Busy);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (InReady !== 1'b1 || Enable !== 1'b0 || DropCount !== 8'd0) begin
            failures++;
            $display("FAIL rst_mid_after got rdy=%0b en=%0b drop=%0d exp rdy=1 en=0 drop=0",
                     InReady, Enable, DropCount);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        InValid   = 1'b0;
        InData    = 4'h0;
        DestMask  = 4'b0000;
        DestReady = 4'b0000;
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_sparse_mask();
        test_stall_drop();
        test_stall_recover();
        test_stall_boundary();
        test_saturate();
        test_reset_mid_send();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
